// File: rtl/sorted_loader.sv
// ---------------------------------------------------------------------------
// sorted_loader
//
// Insertion-sorted array loader. Values arrive one at a time on a
// valid/ready handshake and are placed into an internal array so that
// entries 0..count-1 are always in non-decreasing (unsigned) order whenever
// busy is low. A downstream consumer performs a fixed-depth binary search
// through rd_addr/rd_data; addresses at or beyond count read as all-ones
// so the search always sees a fully sorted array.
//
// Insertion is done by an in-place shift: starting at the tail, larger
// entries are moved up one slot per cycle until the insertion point is
// found, then the new value is written there.
//
// Ports
//   clk       in   single clock, rising-edge active
//   reset     in   asynchronous active-low reset
//   in_data   in   [WIDTH-1:0] value to insert
//   in_valid  in   insert request
//   in_ready  out  insert can be accepted this cycle
//   clear     in   synchronous empty request (wins over an accept)
//   rd_addr   in   [AW-1:0] read address
//   rd_data   out  [WIDTH-1:0] combinational read (all-ones past count)
//   count     out  [AW:0] number of valid entries, 0..DEPTH
//   full      out  count == DEPTH
//   busy      out  insertion in progress, array contents unstable
// ---------------------------------------------------------------------------
module sorted_loader #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       clear,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_INSERT = 2'd2;

    // Storage (intentionally not reset; reads past count are masked)
    logic [WIDTH-1:0] mem [DEPTH];

    logic [1:0]       state, state_nxt;
    logic [AW-1:0]    idx, idx_nxt;
    logic [WIDTH-1:0] val, val_nxt;
    logic [CW-1:0]    count_q, count_nxt;

    logic [AW-1:0]    prev_idx;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    // idx never exceeds DEPTH-1 while an insert is in flight, because an
    // insert is only accepted when count < DEPTH.
    assign prev_idx = idx - AW'(1);

    assign count    = count_q;
    assign full     = (count_q == CW'(DEPTH));
    assign busy     = (state != S_IDLE);
    assign in_ready = (state == S_IDLE) && !full;

    // Entries at or past count read as all-ones so a binary search over
    // the full DEPTH range still sees a sorted sequence.
    assign rd_data  = ({1'b0, rd_addr} < count_q) ? mem[rd_addr] : '1;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        val_nxt   = val;
        count_nxt = count_q;
        mem_we    = 1'b0;
        mem_waddr = idx;
        mem_wdata = val;

        case (state)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    val_nxt   = in_data;
                    idx_nxt   = count_q[AW-1:0];
                    state_nxt = S_SHIFT;
                end
            end

            S_SHIFT: begin
                // Strictly-greater test: equal entries stop the shift, so
                // duplicates land after existing equal values.
                if ((idx != '0) && (mem[prev_idx] > val)) begin
                    mem_we    = 1'b1;
                    mem_waddr = idx;
                    mem_wdata = mem[prev_idx];
                    idx_nxt   = prev_idx;
                end else begin
                    state_nxt = S_INSERT;
                end
            end

            S_INSERT: begin
                mem_we    = 1'b1;
                mem_waddr = idx;
                mem_wdata = val;
                count_nxt = count_q + CW'(1);
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Clear overrides everything, including a same-edge accept and any
        // in-flight shift/insert.
        if (clear) begin
            state_nxt = S_IDLE;
            count_nxt = '0;
            mem_we    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            idx     <= '0;
            val     <= '0;
            count_q <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            val     <= val_nxt;
            count_q <= count_nxt;
        end
    end

    // Writes only occur in SHIFT/INSERT, which reset forces back to IDLE,
    // so an aborted insert leaves no partial update visible through count.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule
